// File: rtl/l2_msg_arbiter_if.sv
// Message bus between the L2 front-end scheduler and its neighbours:
// msg1 request channel, msg3 writeback channel, and the single pipeline port.
interface l2_msg_arbiter_if;
    logic        msg1_valid;
    logic        msg1_ready;
    logic [7:0]  msg1_type;
    logic [25:0] msg1_tag;
    logic [5:0]  msg1_source;
    logic [63:0] msg1_data;
    logic        msg3_valid;
    logic        msg3_ready;
    logic [7:0]  msg3_type;
    logic [25:0] msg3_tag;
    logic [5:0]  msg3_source;
    logic [63:0] msg3_data;
    logic        pipe_valid;
    logic        pipe_ready;
    logic        pipe_chan;
    logic [7:0]  cur_msg_type;
    logic [25:0] cur_msg_tag;
    logic [5:0]  cur_msg_source;
    logic [63:0] cur_msg_data;
    logic        pipe_done;
    logic [1:0]  cur_msg_state;
    logic        timeout_err;

    modport master (
        output msg1_valid, msg1_type, msg1_tag, msg1_source, msg1_data,
        output msg3_valid, msg3_type, msg3_tag, msg3_source, msg3_data,
        output pipe_ready, pipe_done,
        input  msg1_ready, msg3_ready, pipe_valid, pipe_chan,
        input  cur_msg_type, cur_msg_tag, cur_msg_source, cur_msg_data,
        input  cur_msg_state, timeout_err
    );

    modport slave (
        input  msg1_valid, msg1_type, msg1_tag, msg1_source, msg1_data,
        input  msg3_valid, msg3_type, msg3_tag, msg3_source, msg3_data,
        input  pipe_ready, pipe_done,
        output msg1_ready, msg3_ready, pipe_valid, pipe_chan,
        output cur_msg_type, cur_msg_tag, cur_msg_source, cur_msg_data,
        output cur_msg_state, timeout_err
    );
endinterface

// File: rtl/l2_msg_arbiter.sv
// PMESH L2 front-end scheduler: msg3 writebacks win over msg1 requests, with a
// starvation guard; one message in flight. Define L2_ARB_PERF_EN for perf counters.
module l2_msg_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    l2_msg_arbiter_if.slave     bus
`ifdef L2_ARB_PERF_EN
    ,
    output logic [15:0]         perf_msg1_cnt,
    output logic [15:0]         perf_msg3_cnt,
    output logic [15:0]         perf_starve_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    typedef struct packed {
        logic [7:0]  typ;
        logic [25:0] tag;
        logic [5:0]  src;
        logic [63:0] data;
    } msg_t;

    state_e     state_q, state_d;
    msg_t       msg_q, msg_d;
    logic       chan_q, chan_d;
    logic [3:0] starve_q, starve_d;
    logic [7:0] wcnt_q, wcnt_d;
    logic       err_q, err_d;

    logic starved, sel1, sel3, rdy1, rdy3;

    // msg1 overrides msg3 only once it has been passed over STARVE_LIMIT times.
    assign starved = bus.msg1_valid && (starve_q == 4'(STARVE_LIMIT));
    assign sel3    = bus.msg3_valid && !starved;
    assign sel1    = bus.msg1_valid && !sel3;

    always_comb begin
        state_d  = state_q;
        msg_d    = msg_q;
        chan_d   = chan_q;
        starve_d = starve_q;
        wcnt_d   = wcnt_q;
        err_d    = err_q;
        rdy1     = 1'b0;
        rdy3     = 1'b0;
        case (state_q)
            IDLE: begin
                rdy1 = sel1;
                rdy3 = sel3;
                if (sel3) begin
                    msg_d   = '{typ: bus.msg3_type, tag: bus.msg3_tag,
                                src: bus.msg3_source, data: bus.msg3_data};
                    chan_d  = 1'b1;
                    state_d = ISSUE;
                    if (!bus.msg1_valid)
                        starve_d = '0;
                    else if (starve_q != 4'(STARVE_LIMIT))
                        starve_d = starve_q + 4'd1;
                end else if (sel1) begin
                    msg_d    = '{typ: bus.msg1_type, tag: bus.msg1_tag,
                                 src: bus.msg1_source, data: bus.msg1_data};
                    chan_d   = 1'b0;
                    starve_d = '0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.pipe_ready) begin
                    state_d = WAIT;
                    wcnt_d  = '0;
                end
            end
            WAIT: begin
                if (bus.pipe_done) begin
                    state_d = IDLE;
                end else if (wcnt_q == 8'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            msg_q    <= '0;
            chan_q   <= 1'b0;
            starve_q <= '0;
            wcnt_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            msg_q    <= msg_d;
            chan_q   <= chan_d;
            starve_q <= starve_d;
            wcnt_q   <= wcnt_d;
            err_q    <= err_d;
        end
    end

    assign bus.msg1_ready     = rdy1;
    assign bus.msg3_ready     = rdy3;
    assign bus.pipe_valid     = (state_q == ISSUE);
    assign bus.pipe_chan      = chan_q;
    assign bus.cur_msg_type   = msg_q.typ;
    assign bus.cur_msg_tag    = msg_q.tag;
    assign bus.cur_msg_source = msg_q.src;
    assign bus.cur_msg_data   = msg_q.data;
    assign bus.cur_msg_state  = state_q;
    assign bus.timeout_err    = err_q;

`ifdef L2_ARB_PERF_EN
    logic [15:0] pm1_q, pm1_d, pm3_q, pm3_d, pst_q, pst_d;

    always_comb begin
        pm1_d = pm1_q;
        pm3_d = pm3_q;
        pst_d = pst_q;
        if (rdy1 && pm1_q != 16'hFFFF) pm1_d = pm1_q + 16'd1;
        if (rdy3 && pm3_q != 16'hFFFF) pm3_d = pm3_q + 16'd1;
        if (rdy1 && starved && bus.msg3_valid && pst_q != 16'hFFFF) pst_d = pst_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pm1_q <= '0;
            pm3_q <= '0;
            pst_q <= '0;
        end else begin
            pm1_q <= pm1_d;
            pm3_q <= pm3_d;
            pst_q <= pst_d;
        end
    end

    assign perf_msg1_cnt   = pm1_q;
    assign perf_msg3_cnt   = pm3_q;
    assign perf_starve_cnt = pst_q;
`endif

endmodule

// File: doc/l2_msg_arbiter.md
Name: l2_msg_arbiter

Overview:
- Front-end scheduler for the PMESH L2 model.
- Arbitrates between the msg1 request channel and the msg3 writeback channel (e.g. WB_REQ, type 0x0C).
- Latches one winning message into the current-message registers, issues it to the single L2 processing pipeline, and holds off both channels until the pipeline signals completion.
- Writebacks have priority; a starvation guard bounds how long msg1 can be blocked.

Parameters:
- STARVE_LIMIT, 4, consecutive msg3 grants allowed while msg1 is waiting; legal range 1..15.
- TIMEOUT, 64, maximum cycles in WAIT before abort; legal range 2..255.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- msg1_valid  in  1  request message present.
- msg1_ready  out  1  request accepted this cycle when valid&&ready.
- msg1_type  in  8  request type.
- msg1_tag  in  26  request tag.
- msg1_source  in  6  request source id.
- msg1_data  in  64  request data.
- msg3_valid  in  1  writeback message present.
- msg3_ready  out  1  writeback accepted this cycle when valid&&ready.
- msg3_type  in  8  writeback type.
- msg3_tag  in  26  writeback tag.
- msg3_source  in  6  writeback source id.
- msg3_data  in  64  writeback data.
- pipe_valid  out  1  current message offered to the pipeline.
- pipe_ready  in  1  pipeline takes the message.
- pipe_chan  out  1  channel of the current message: 0=msg1, 1=msg3.
- cur_msg_type  out  8  latched type.
- cur_msg_tag  out  26  latched tag.
- cur_msg_source  out  6  latched source.
- cur_msg_data  out  64  latched data.
- pipe_done  in  1  pipeline finished the current message.
- cur_msg_state  out  2  FSM state.
- timeout_err  out  1  sticky abort flag.

Behaviour:
- Reset (async assert, sync release): cur_msg_state=IDLE(0); pipe_valid=0; pipe_chan=0; all cur_msg_* = 0; starvation count=0; timeout_err=0.
- FSM states: IDLE=0, ISSUE=1, WAIT=2; encoding 3 unused and recovers to IDLE at the next edge.
- IDLE:
  - msg1_ready/msg3_ready are combinational; at most one is high, and only for the selected channel.
  - Selection: msg3 if msg3_valid, unless msg1_valid and starve_cnt==STARVE_LIMIT, in which case msg1. Otherwise msg1 if msg1_valid.
  - On accept: latch type/tag/source/data and pipe_chan, then go to ISSUE.
  - With no valid input, stay in IDLE; both readies stay low unless the channel is valid.
- ISSUE:
  - pipe_valid=1; cur_msg_* and pipe_chan held stable.
  - pipe_ready=1 → WAIT at the next edge; pipe_valid drops.
  - Both readies are 0.
- WAIT:
  - Cycle counter starts at 0 on entry.
  - pipe_done=1 → IDLE.
  - Counter reaching TIMEOUT-1 without done → set timeout_err and go to IDLE.
  - pipe_done outside WAIT is ignored.
- Latency:
  - Accept at edge N → pipe_valid high in cycle N+1.
  - Minimum spacing between accepts is 3 cycles (accept, issue with pipe_ready=1, done).
- Starvation counter:
  - msg3 granted while msg1_valid=1 → starve_cnt+1, saturating at STARVE_LIMIT.
  - msg3 granted while msg1_valid=0 → starve_cnt=0.
  - msg1 granted → starve_cnt=0.
- Simultaneous valid on both channels: exactly one accepted; the other sees ready=0 and must hold.
- Input fields are sampled only on the accept edge.
- rst_n low mid-operation: immediately returns to IDLE with all outputs at reset values; the in-flight message is discarded.
- timeout_err clears only on reset.

Optional Feature:
- Macro L2_ARB_PERF_EN.
- When defined:
  - Adds outputs perf_msg1_cnt[15:0], perf_msg3_cnt[15:0] and perf_starve_cnt[15:0].
  - Each counts accepts per channel and forced msg1 grants, respectively.
  - All saturate at 0xFFFF and reset to 0.
- When undefined: these ports and their logic are absent; behaviour is otherwise identical.

Test Plan:
- Single msg1 (type 0x01, tag 0x0ABCDEF, src 5, data 0x1234): msg1_ready=1 in IDLE → pipe_valid next cycle with the same fields and pipe_chan=0. pipe_ready=1 → WAIT; pipe_done → IDLE.
- Both valid continuously with STARVE_LIMIT=4, pipeline always ready and done 1 cycle after ISSUE: grant sequence msg3×4, msg1, msg3×4, msg1.
- msg3 WB_REQ (type 0x0C, data 0xDEADBEEF) with pipe_ready held low 10 cycles: stays in ISSUE with stable fields and both readies 0. pipe_ready=1 → WAIT.
- WAIT with no pipe_done for TIMEOUT=64 cycles: timeout_err=1 and IDLE after 64 cycles; a subsequent message is accepted normally; timeout_err stays 1.
- rst_n asserted during WAIT: cur_msg_state=0, pipe_valid=0, cur_msg_*=0 immediately, without waiting for a clock edge.
- With L2_ARB_PERF_EN: after 3 msg1 and 5 msg3 accepts, perf_msg1_cnt=3 and perf_msg3_cnt=5.
